param_serializer: RTL and testbench

Parametrised parallel-to-serial converter; the successor to the team's fixed 12-bit load/send serializer.
- Generalised in word width and bit order.
- Adds a one-word holding buffer so frames go out back-to-back with no gap.
- Adds a send-gated stall, frame markers and a load-ready handshake.
- Sits between a parallel producer (ADC/register bank) and a single-wire serial sink.

---
 rtl/param_serializer_pkg.sv | 14 +
 rtl/ser_hold_buf.sv | 35 +++
 rtl/param_serializer.sv | 128 ++++++++++++
 tb/tb_param_serializer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_serializer_pkg.sv
// Shared types and helpers for the parametrised serializer and its buffer.
package param_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a WIDTH-bit frame; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry valid/ready holding register between a parallel producer and a consumer.
module ser_hold_buf #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_take,
  output logic             o_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A load is only honoured while empty, so load and take never coincide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load && !r_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_take) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_ready = ~r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer, send-gated stall and frame markers.
module param_serializer
  import param_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = 12,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             load_ready,
  input  logic             send,
  output logic             data_out,
  output logic             out_valid,
  output logic             sof,
  output logic             done,
  output logic             busy
);

  localparam int unsigned      CntW    = cnt_w(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_shreg, w_shreg_d;
  logic             r_dout, w_dout_d;
  logic             r_valid, w_valid_d;
  logic             r_sof, w_sof_d;
  logic             r_done, w_done_d;

  logic             w_hb_valid;
  logic             w_hb_ready;
  logic [WIDTH-1:0] w_hb_data;
  logic             w_take;
  logic             w_cur_bit;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;

  ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .i_clk  (CLK),
    .i_rst  (rst),
    .i_load (load),
    .i_data (data_in),
    .i_take (w_take),
    .o_valid(w_hb_valid),
    .o_ready(w_hb_ready),
    .o_data (w_hb_data)
  );

  assign w_cur_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
  assign w_last    = (r_cnt == LastCnt);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_shreg_d = r_shreg;
    w_dout_d  = r_dout;
    w_valid_d = 1'b0;
    w_sof_d   = 1'b0;
    w_done_d  = 1'b0;
    w_take    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_dout_d = IDLE_LEVEL;
        if (w_hb_valid) begin
          w_shreg_d = w_hb_data;
          w_take    = 1'b1;
          w_cnt_d   = '0;
          w_state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // With send low everything freezes and data_out keeps its last bit.
        if (send) begin
          w_dout_d  = w_cur_bit;
          w_shreg_d = w_shifted;
          w_valid_d = 1'b1;
          w_sof_d   = (r_cnt == '0);
          w_done_d  = w_last;
          w_cnt_d   = r_cnt + CntW'(1);
          if (w_last) begin
            w_cnt_d = '0;
            if (w_hb_valid) begin
              w_shreg_d = w_hb_data;
              w_take    = 1'b1;
            end else begin
              w_state_d = ST_IDLE;
            end
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_dout  <= IDLE_LEVEL;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_shreg <= w_shreg_d;
      r_dout  <= w_dout_d;
      r_valid <= w_valid_d;
      r_sof   <= w_sof_d;
      r_done  <= w_done_d;
    end
  end

  assign load_ready = w_hb_ready;
  assign data_out   = r_dout;
  assign out_valid  = r_valid;
  assign sof        = r_sof;
  assign done       = r_done;
  assign busy       = (r_state == ST_SHIFT) | w_hb_valid;

endmodule

// File: tb/tb_param_serializer.sv
// Bench: 12-bit LSB-first instance against a queue-based frame model, plus a directed 8-bit MSB-first instance.
module tb_param_serializer;

  logic        CLK = 1'b0;
  logic        rst, load, send, load8;
  logic [11:0] data_in;
  logic [7:0]  data8;
  logic        load_ready, data_out, out_valid, sof, done, busy;
  logic        load_ready8, dout8, ov8, sof8, done8, busy8;

  always #5 CLK = ~CLK;

  param_serializer #(.WIDTH(12), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut (
    .CLK(CLK), .rst(rst), .data_in(data_in), .load(load), .load_ready(load_ready),
    .send(send), .data_out(data_out), .out_valid(out_valid), .sof(sof), .done(done),
    .busy(busy)
  );

  param_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut8 (
    .CLK(CLK), .rst(rst), .data_in(data8), .load(load8), .load_ready(load_ready8),
    .send(send), .data_out(dout8), .out_valid(ov8), .sof(sof8), .done(done8),
    .busy(busy8)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Frame model: remaining bits of the active frame (empty = idle) and the holding buffer.
  bit          mq[$];
  int          m_pos;
  logic        m_hbv;
  logic [11:0] m_hbd;
  logic        e_dout, e_ov, e_sof, e_done;

  // Observation trackers for directed checks.
  int          cyc = 0, nvalid, nframes, run, maxrun, sof_cyc, done_cyc;
  logic [11:0] cap12, last_word;
  int          n8, sof8_at, done8_at;
  logic [7:0]  cap8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void start_frame(input logic [11:0] w);
    mq.delete();
    for (int i = 0; i < 12; i++) mq.push_back(w[i]);
    m_pos = 0;
  endfunction

  function automatic void model_edge(input logic r, input logic l, input logic [11:0] d,
                                     input logic s);
    logic acc;
    if (r) begin
      mq.delete();
      m_hbv = 1'b0;
      e_dout = 1'b0; e_ov = 1'b0; e_sof = 1'b0; e_done = 1'b0;
      return;
    end
    acc = l && !m_hbv;
    e_ov = 1'b0; e_sof = 1'b0; e_done = 1'b0;
    if (mq.size() == 0) begin
      e_dout = 1'b0;
      if (m_hbv) begin
        start_frame(m_hbd);
        m_hbv = 1'b0;
      end
    end else if (s) begin
      e_dout = mq.pop_front();
      e_ov   = 1'b1;
      e_sof  = (m_pos == 0);
      m_pos++;
      e_done = (mq.size() == 0);
      if (e_done && m_hbv) begin
        start_frame(m_hbd);
        m_hbv = 1'b0;
      end
    end
    if (acc) begin
      m_hbv = 1'b1;
      m_hbd = d;
    end
  endfunction

  task automatic step(input logic r, input logic l, input logic [11:0] d, input logic s,
                      input logic l8 = 1'b0, input logic [7:0] d8 = 8'h00);
    rst = r; load = l; data_in = d; send = s; load8 = l8; data8 = d8;
    @(posedge CLK);
    model_edge(r, l, d, s);
    #1;
    cyc++;
    chk("data_out", {31'b0, data_out}, {31'b0, e_dout});
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
    chk("sof", {31'b0, sof}, {31'b0, e_sof});
    chk("done", {31'b0, done}, {31'b0, e_done});
    chk("busy", {31'b0, busy}, {31'b0, logic'((mq.size() != 0) || m_hbv)});
    chk("load_ready", {31'b0, load_ready}, {31'b0, ~m_hbv});
    if (out_valid) begin
      cap12 = {data_out, cap12[11:1]};
      nvalid++;
      run++;
      if (sof) sof_cyc = cyc;
      if (done) begin
        last_word = cap12;
        nframes++;
        done_cyc = cyc;
      end
    end else begin
      run = 0;
    end
    if (run > maxrun) maxrun = run;
    if (ov8) begin
      if (n8 < 8) cap8 = {cap8[6:0], dout8};
      if (sof8) sof8_at = n8;
      if (done8) done8_at = n8;
      n8++;
    end
  endtask

  task automatic clear_obs();
    nvalid = 0; nframes = 0; run = 0; maxrun = 0; sof_cyc = -1; done_cyc = -1;
    cap12 = '0; last_word = '0;
  endtask

  initial begin
    clear_obs();
    n8 = 0; sof8_at = -1; done8_at = -1; cap8 = '0;

    // Reset, with load/send asserted to show reset dominates.
    step(1'b1, 1'b1, 12'hFFF, 1'b1);
    step(1'b1, 1'b0, 12'h000, 1'b0);
    chk("rst_data_out", {31'b0, data_out}, 32'd0);
    chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst8_data_out_idle", {31'b0, dout8}, 32'd1);
    chk("rst8_out_valid", {31'b0, ov8}, 32'd0);
    chk("rst8_load_ready", {31'b0, load_ready8}, 32'd1);

    // 8-bit MSB-first: C3 -> 1,1,0,0,0,0,1,1.
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 8'hC3);
    chk("w8_busy_after_load", {31'b0, busy8}, 32'd1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("w8_bits", {24'b0, cap8}, 32'hC3);
    chk("w8_valid_count", n8, 32'd8);
    chk("w8_sof_pos", sof8_at, 32'd0);
    chk("w8_done_pos", done8_at, 32'd7);
    chk("w8_idle_level", {31'b0, dout8}, 32'd1);
    chk("w8_idle_valid", {31'b0, ov8}, 32'd0);

    // Single word, send held high.
    clear_obs();
    step(1'b0, 1'b1, 12'hA5C, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("single_no_bit_yet", {31'b0, out_valid}, 32'd0);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("single_first_bit_sof", {30'b0, out_valid, sof}, 32'd3);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("single_word", {20'b0, last_word}, 32'hA5C);
    chk("single_count", nvalid, 32'd12);
    chk("single_idle", {30'b0, out_valid, data_out}, 32'd0);

    // Back-to-back frames.
    clear_obs();
    step(1'b0, 1'b1, 12'h001, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b1, 12'h800, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("b2b_count", nvalid, 32'd24);
    chk("b2b_run", maxrun, 32'd24);
    chk("b2b_frames", nframes, 32'd2);
    chk("b2b_last_word", {20'b0, last_word}, 32'h800);

    // Stall for 3 cycles after bit 5.
    clear_obs();
    step(1'b0, 1'b1, 12'hFFF, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("stall_bits_before", nvalid, 32'd5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h000, 1'b0);
    chk("stall_hold", {30'b0, out_valid, data_out}, 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("stall_count", nvalid, 32'd12);
    chk("stall_span", done_cyc - sof_cyc + 1, 32'd15);

    // Overflow: a load while the buffer is full is dropped.
    clear_obs();
    step(1'b0, 1'b1, 12'h0F0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b1, 12'h3C3, 1'b1);
    chk("ovf_not_ready", {31'b0, load_ready}, 32'd0);
    step(1'b0, 1'b1, 12'h123, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("ovf_frames", nframes, 32'd2);
    chk("ovf_kept_word", {20'b0, last_word}, 32'h3C3);

    // Reset mid-frame at bit 6 with a word buffered.
    clear_obs();
    step(1'b0, 1'b1, 12'h555, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b1, 12'hABC, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("midrst_bits_before", nvalid, 32'd6);
    step(1'b1, 1'b1, 12'h777, 1'b1);
    chk("midrst_outputs", {27'b0, data_out, out_valid, sof, done, busy}, 32'd0);
    chk("midrst_ready", {31'b0, load_ready}, 32'd1);
    clear_obs();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("midrst_silent", nvalid, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(logic'($urandom_range(0, 149) == 0), logic'($urandom_range(0, 2) == 0),
           12'($urandom), logic'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
